pipe_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It generates the enable and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers, sequencing three events: load-use stalls, taken-branch flushes, and multi-cycle multiply/divide occupancy of EX. The block sits beside the decoder in ID; all hazard inputs come from the ID stage and the ID/EX register outputs.

---
 rtl/pipe_hazard_ctrl.sv | 101 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use stalls, taken-branch
// flushes and multi-cycle mult/div occupancy of EX.
module pipe_hazard_ctrl #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_is_muldiv,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        busy,
  output logic [15:0] stall_cycles
);

  typedef enum logic {RUN, MULDIV} state_e;

  localparam logic [3:0] CNT_RELOAD = 4'(MULDIV_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_q, stall_d;

  logic load_use, hold;
  logic pc_en_c, ifid_en_c, ifid_flush_c, idex_en_c, idex_flush_c, exmem_flush_c, busy_c;

  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign hold     = (state_q == MULDIV) && (cnt_q != 4'd0);

  always_comb begin
    pc_en_c       = 1'b1;
    ifid_en_c     = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_en_c     = 1'b1;
    idex_flush_c  = 1'b0;
    exmem_flush_c = 1'b0;
    busy_c        = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;

    if (hold) begin
      // EX holds the mult/div, so branch and load signals from EX are stale
      pc_en_c       = 1'b0;
      ifid_en_c     = 1'b0;
      idex_en_c     = 1'b0;
      exmem_flush_c = 1'b1;
      busy_c        = 1'b1;
      cnt_d         = cnt_q - 4'd1;
    end else begin
      state_d = RUN;
      if (ex_branch_taken) begin
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
      end else if (load_use) begin
        pc_en_c      = 1'b0;
        ifid_en_c    = 1'b0;
        idex_flush_c = 1'b1;
      end else if (id_is_muldiv && (MULDIV_CYCLES > 1)) begin
        state_d = MULDIV;
        cnt_d   = CNT_RELOAD;
      end
    end

    stall_d = stall_q;
    if (!pc_en_c && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    pc_en        = pc_en_c       && !rst;
    ifid_en      = ifid_en_c     && !rst;
    ifid_flush   = ifid_flush_c  && !rst;
    idex_en      = idex_en_c     && !rst;
    idex_flush   = idex_flush_c  && !rst;
    exmem_flush  = exmem_flush_c && !rst;
    busy         = busy_c        && !rst;
    stall_cycles = rst ? '0 : stall_q;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a second instance with MULDIV_CYCLES=1
// shares the stimulus.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        id_uses_rt = 1'b0, id_is_muldiv = 1'b0, ex_memread = 1'b0, ex_branch_taken = 1'b0;

  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, busy;
  logic [15:0] stall_cycles;
  logic        pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_flush1, exmem_flush1, busy1;
  logic [15:0] stall_cycles1;

  int n_cmp = 0;
  int n_bad = 0;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, busy}
  localparam logic [6:0] ZERO = 7'b0000000;
  localparam logic [6:0] RUNV = 7'b1101000;
  localparam logic [6:0] LU   = 7'b0001100;
  localparam logic [6:0] BR   = 7'b1111100;
  localparam logic [6:0] MD   = 7'b0000011;

  logic [6:0] ctl, ctl1;
  assign ctl  = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, busy};
  assign ctl1 = {pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_flush1, exmem_flush1, busy1};

  pipe_hazard_ctrl #(.MULDIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_muldiv(id_is_muldiv), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .busy(busy), .stall_cycles(stall_cycles)
  );

  pipe_hazard_ctrl #(.MULDIV_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_muldiv(id_is_muldiv), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .pc_en(pc_en1), .ifid_en(ifid_en1),
    .ifid_flush(ifid_flush1), .idex_en(idex_en1), .idex_flush(idex_flush1),
    .exmem_flush(exmem_flush1), .busy(busy1), .stall_cycles(stall_cycles1)
  );

  always #5 clk = ~clk;

  // Advance to the next negedge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_in();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rt = 1'b0; id_is_muldiv = 1'b0; ex_memread = 1'b0; ex_branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; clear_in();
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #1;
    n_cmp++; if (ctl !== ZERO) begin n_bad++; $display("FAIL reset_ctl got %b want %b", ctl, ZERO); end
    step();
    n_cmp++; if (stall_cycles !== 16'd0) begin n_bad++; $display("FAIL reset_stall got %0d want 0", stall_cycles); end
    clear_in();
    rst = 1'b0;
    #1;
    n_cmp++; if (ctl !== RUNV) begin n_bad++; $display("FAIL reset_release_ctl got %b want %b", ctl, RUNV); end
    n_cmp++; if (stall_cycles !== 16'd0) begin n_bad++; $display("FAIL reset_release_stall got %0d want 0", stall_cycles); end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #1;
    n_cmp++; if (ctl !== LU) begin n_bad++; $display("FAIL lu_ctl got %b want %b", ctl, LU); end
    step();
    clear_in();
    #1;
    n_cmp++; if (ctl !== RUNV) begin n_bad++; $display("FAIL lu_after_ctl got %b want %b", ctl, RUNV); end
    n_cmp++; if (stall_cycles !== 16'd1) begin n_bad++; $display("FAIL lu_stall got %0d want 1", stall_cycles); end
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    n_cmp++; if (ctl !== RUNV) begin n_bad++; $display("FAIL lu_r0_ctl got %b want %b", ctl, RUNV); end
    step();
    n_cmp++; if (stall_cycles !== 16'd1) begin n_bad++; $display("FAIL lu_r0_stall got %0d want 1", stall_cycles); end
    clear_in();
  endtask

  task automatic test_rt_gating();
    do_reset();
    ex_memread = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
    #1;
    n_cmp++; if (ctl !== RUNV) begin n_bad++; $display("FAIL rt_unused_ctl got %b want %b", ctl, RUNV); end
    id_uses_rt = 1'b1;
    #1;
    n_cmp++; if (ctl !== LU) begin n_bad++; $display("FAIL rt_used_ctl got %b want %b", ctl, LU); end
    ex_memread = 1'b0;
    #1;
    n_cmp++; if (ctl !== RUNV) begin n_bad++; $display("FAIL rt_noload_ctl got %b want %b", ctl, RUNV); end
    clear_in();
  endtask

  task automatic test_branch_priority();
    do_reset();
    ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; id_is_muldiv = 1'b1;
    #1;
    n_cmp++; if (ctl !== BR) begin n_bad++; $display("FAIL br_ctl got %b want %b", ctl, BR); end
    step();
    clear_in();
    #1;
    n_cmp++; if (ctl !== RUNV) begin n_bad++; $display("FAIL br_no_muldiv_ctl got %b want %b", ctl, RUNV); end
    n_cmp++; if (stall_cycles !== 16'd0) begin n_bad++; $display("FAIL br_stall got %0d want 0", stall_cycles); end
  endtask

  task automatic test_lu_defers_muldiv();
    do_reset();
    ex_memread = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; id_is_muldiv = 1'b1;
    #1;
    n_cmp++; if (ctl !== LU) begin n_bad++; $display("FAIL defer_lu_ctl got %b want %b", ctl, LU); end
    step();
    ex_memread = 1'b0;
    #1;
    n_cmp++; if (ctl !== RUNV) begin n_bad++; $display("FAIL defer_issue_ctl got %b want %b", ctl, RUNV); end
    step();
    clear_in();
    #1;
    n_cmp++; if (ctl !== MD) begin n_bad++; $display("FAIL defer_busy_ctl got %b want %b", ctl, MD); end
    step(); step(); step();
    n_cmp++; if (stall_cycles !== 16'd4) begin n_bad++; $display("FAIL defer_stall got %0d want 4", stall_cycles); end
  endtask

  task automatic test_muldiv();
    do_reset();
    id_is_muldiv = 1'b1;
    #1;
    n_cmp++; if (ctl !== RUNV) begin n_bad++; $display("FAIL md_issue_ctl got %b want %b", ctl, RUNV); end
    step();
    clear_in();
    #1;
    n_cmp++; if (ctl !== MD) begin n_bad++; $display("FAIL md_c1_ctl got %b want %b", ctl, MD); end
    n_cmp++; if (ctl1 !== RUNV) begin n_bad++; $display("FAIL md1_ctl got %b want %b", ctl1, RUNV); end
    step();
    ex_branch_taken = 1'b1;
    #1;
    n_cmp++; if (ctl !== MD) begin n_bad++; $display("FAIL md_c2_branch_ctl got %b want %b", ctl, MD); end
    step();
    clear_in(); ex_memread = 1'b1; ex_rt = 5'd2; id_rs = 5'd2;
    #1;
    n_cmp++; if (ctl !== MD) begin n_bad++; $display("FAIL md_c3_load_ctl got %b want %b", ctl, MD); end
    step();
    clear_in();
    #1;
    n_cmp++; if (ctl !== RUNV) begin n_bad++; $display("FAIL md_release_ctl got %b want %b", ctl, RUNV); end
    n_cmp++; if (stall_cycles !== 16'd3) begin n_bad++; $display("FAIL md_stall got %0d want 3", stall_cycles); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    id_is_muldiv = 1'b1;
    step();
    clear_in();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (ctl !== MD) begin n_bad++; $display("FAIL b2b_first_c%0d got %b want %b", i, ctl, MD); end
      step();
    end
    id_is_muldiv = 1'b1;
    #1;
    n_cmp++; if (ctl !== RUNV) begin n_bad++; $display("FAIL b2b_reissue_ctl got %b want %b", ctl, RUNV); end
    step();
    clear_in();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (ctl !== MD) begin n_bad++; $display("FAIL b2b_second_c%0d got %b want %b", i, ctl, MD); end
      step();
    end
    #1;
    n_cmp++; if (ctl !== RUNV) begin n_bad++; $display("FAIL b2b_release_ctl got %b want %b", ctl, RUNV); end
    n_cmp++; if (stall_cycles !== 16'd6) begin n_bad++; $display("FAIL b2b_stall got %0d want 6", stall_cycles); end
    n_cmp++; if (stall_cycles1 !== 16'd0) begin n_bad++; $display("FAIL b2b_md1_stall got %0d want 0", stall_cycles1); end
  endtask

  task automatic test_reset_mid_muldiv();
    do_reset();
    id_is_muldiv = 1'b1;
    step();
    clear_in();
    step();
    rst = 1'b1;
    #1;
    n_cmp++; if (ctl !== ZERO) begin n_bad++; $display("FAIL rmid_ctl got %b want %b", ctl, ZERO); end
    n_cmp++; if (stall_cycles !== 16'd0) begin n_bad++; $display("FAIL rmid_stall_out got %0d want 0", stall_cycles); end
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if (ctl !== RUNV) begin n_bad++; $display("FAIL rmid_release_ctl got %b want %b", ctl, RUNV); end
    step();
    n_cmp++; if (ctl !== RUNV) begin n_bad++; $display("FAIL rmid_next_ctl got %b want %b", ctl, RUNV); end
    n_cmp++; if (stall_cycles !== 16'd0) begin n_bad++; $display("FAIL rmid_stall got %0d want 0", stall_cycles); end
  endtask

  task automatic test_saturation();
    do_reset();
    ex_memread = 1'b1; ex_rt = 5'd6; id_rs = 5'd6;
    for (int i = 0; i < 65534; i++) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (stall_cycles !== 16'hFFFE) begin n_bad++; $display("FAIL sat_pre got %h want fffe", stall_cycles); end
    step();
    n_cmp++; if (stall_cycles !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hit got %h want ffff", stall_cycles); end
    for (int i = 0; i < 5; i++) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (stall_cycles !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold got %h want ffff", stall_cycles); end
    n_cmp++; if (ctl !== LU) begin n_bad++; $display("FAIL sat_ctl got %b want %b", ctl, LU); end
    clear_in();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rt_gating();
    test_branch_priority();
    test_lu_defers_muldiv();
    test_muldiv();
    test_back_to_back();
    test_reset_mid_muldiv();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
